// File: rtl/seg_text_pkg.sv
// Shared types and constants for the segment text scroller and its glyph decoder.
package seg_text_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_WRAP   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_glyph_rom.sv
// ASCII to active-low {g..a} segment decoder; purely combinational, no backpressure.
// Covers A-Z (W has no sensible glyph), 0-9, space and '-'; anything else is blank.
module seg7_glyph_rom
    import seg_text_pkg::*;
(
    input  logic [7:0] i_char,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_char)
            "A": o_seg = ~7'h77;
            "B": o_seg = ~7'h7C;
            "C": o_seg = ~7'h39;
            "D": o_seg = ~7'h5E;
            "E": o_seg = ~7'h79;
            "F": o_seg = ~7'h71;
            "G": o_seg = ~7'h3D;
            "H": o_seg = ~7'h74;
            "I": o_seg = ~7'h30;
            "J": o_seg = ~7'h1E;
            "K": o_seg = ~7'h75;
            "L": o_seg = ~7'h38;
            "M": o_seg = ~7'h37;
            "N": o_seg = ~7'h54;
            "O": o_seg = ~7'h3F;
            "P": o_seg = ~7'h73;
            "Q": o_seg = ~7'h67;
            "R": o_seg = ~7'h50;
            "S": o_seg = ~7'h6D;
            "T": o_seg = ~7'h78;
            "U": o_seg = ~7'h3E;
            "V": o_seg = ~7'h1C;
            "X": o_seg = ~7'h76;
            "Y": o_seg = ~7'h6E;
            "Z": o_seg = ~7'h5B;
            "0": o_seg = ~7'h3F;
            "1": o_seg = ~7'h06;
            "2": o_seg = ~7'h5B;
            "3": o_seg = ~7'h4F;
            "4": o_seg = ~7'h66;
            "5": o_seg = ~7'h6D;
            "6": o_seg = ~7'h7D;
            "7": o_seg = ~7'h07;
            "8": o_seg = ~7'h7F;
            "9": o_seg = ~7'h6F;
            "-": o_seg = ~7'h40;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_text_scroller.sv
// Double-buffered scrolling text engine for NUM_DIGITS active-low 7-segment digits.
// hex_out is registered one clk behind scroll_pos/bank/phase; no backpressure, writes and commits always accepted.
module seg_text_scroller
    import seg_text_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_DEPTH  = 32,
    parameter int TICK_DIV   = 25_000_000,
    parameter int BLINK_DIV  = 12_500_000
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0]   i_wr_addr,
    input  logic [7:0]                     i_wr_char,
    input  logic                           i_commit,
    input  logic [$clog2(MSG_DEPTH+1)-1:0] i_msg_len,
    input  logic [1:0]                     i_mode,
    output logic [7*NUM_DIGITS-1:0]        o_hex_out,
    output logic [$clog2(MSG_DEPTH)-1:0]   o_scroll_pos,
    output logic                           o_wrap_pulse
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = $clog2(MSG_DEPTH + 1);
    localparam int IW = LW + $clog2(NUM_DIGITS + 1) + 1;
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    logic [7:0]              r_mem [2][MSG_DEPTH];
    logic                    r_act;
    logic [LW-1:0]           r_len;
    mode_t                   r_mode;
    dir_t                    r_dir;
    logic                    r_phase;
    logic [TW-1:0]           r_tick;
    logic [BW-1:0]           r_blink;
    logic [AW-1:0]           r_pos;
    logic                    r_wrap_pulse;
    logic [7*NUM_DIGITS-1:0] r_hex;

    logic                    w_step;
    logic                    w_blink_step;
    logic [LW-1:0]           w_commit_len;
    logic [IW-1:0]           w_len_i;
    logic [IW-1:0]           w_pos_i;
    logic [AW-1:0]           w_pos_nxt;
    dir_t                    w_dir_nxt;
    logic                    w_pulse_nxt;
    logic                    w_blank_all;
    logic [IW-1:0]           w_idx [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] w_hex_nxt;

    assign w_step       = (r_tick == TW'(TICK_DIV - 1));
    assign w_blink_step = (r_blink == BW'(BLINK_DIV - 1));
    assign w_commit_len = (i_msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : i_msg_len;
    assign w_len_i      = IW'(r_len);
    assign w_pos_i      = IW'(r_pos);
    assign w_blank_all  = (r_mode == MODE_BLINK) && !r_phase;

    // Host writes always target the inactive bank, including the cycle of a commit.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && (int'(i_wr_addr) < MSG_DEPTH))
            r_mem[!r_act][i_wr_addr] <= i_wr_char;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_act        <= 1'b0;
            r_len        <= '0;
            r_mode       <= MODE_STATIC;
            r_dir        <= DIR_UP;
            r_phase      <= 1'b1;
            r_tick       <= '0;
            r_blink      <= '0;
            r_pos        <= '0;
            r_wrap_pulse <= 1'b0;
        end else if (i_commit) begin
            r_act        <= !r_act;
            r_len        <= w_commit_len;
            r_mode       <= mode_t'(i_mode);
            r_dir        <= DIR_UP;
            r_phase      <= 1'b1;
            r_tick       <= '0;
            r_blink      <= '0;
            r_pos        <= '0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_tick       <= w_step ? '0 : r_tick + 1'b1;
            r_blink      <= w_blink_step ? '0 : r_blink + 1'b1;
            if (w_blink_step)
                r_phase <= !r_phase;
            r_pos        <= w_pos_nxt;
            r_dir        <= w_dir_nxt;
            r_wrap_pulse <= w_pulse_nxt;
        end
    end

    // Bounce turns around at either end on a step of its own, without moving.
    always_comb begin
        w_pos_nxt   = r_pos;
        w_dir_nxt   = r_dir;
        w_pulse_nxt = 1'b0;
        if (w_step) begin
            case (r_mode)
                MODE_WRAP: begin
                    if (w_len_i > IW'(1)) begin
                        if (w_pos_i == w_len_i - IW'(1)) begin
                            w_pos_nxt   = '0;
                            w_pulse_nxt = 1'b1;
                        end else begin
                            w_pos_nxt = r_pos + 1'b1;
                        end
                    end
                end
                MODE_BOUNCE: begin
                    if (w_len_i > IW'(NUM_DIGITS)) begin
                        if (r_dir == DIR_UP) begin
                            if (w_pos_i == w_len_i - IW'(NUM_DIGITS))
                                w_dir_nxt = DIR_DOWN;
                            else
                                w_pos_nxt = r_pos + 1'b1;
                        end else if (r_pos == '0) begin
                            w_dir_nxt   = DIR_UP;
                            w_pulse_nxt = 1'b1;
                        end else begin
                            w_pos_nxt = r_pos - 1'b1;
                        end
                    end
                end
                default: w_pos_nxt = '0;
            endcase
        end
    end

    // Wrap mode walks the index modulo len one digit at a time, avoiding a divider.
    always_comb begin
        logic [IW-1:0] v_run;
        v_run = w_pos_i;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_idx[k] = v_run;
            if ((r_mode == MODE_WRAP) && (v_run == w_len_i - IW'(1)))
                v_run = '0;
            else
                v_run = v_run + IW'(1);
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic [7:0] w_char;
        logic [6:0] w_glyph;

        assign w_char = r_mem[r_act][w_idx[k][AW-1:0]];

        seg7_glyph_rom u_rom (
            .i_char (w_char),
            .o_seg  (w_glyph)
        );

        assign w_hex_nxt[7*k +: 7] = (w_blank_all || (w_idx[k] >= w_len_i)) ? SEG_BLANK : w_glyph;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_hex <= '1;
        else
            r_hex <= w_hex_nxt;
    end

    assign o_hex_out    = r_hex;
    assign o_scroll_pos = r_pos;
    assign o_wrap_pulse = r_wrap_pulse;

endmodule

// File: tb/tb_seg_text_scroller.sv
// Randomised and directed bench for seg_text_scroller against a closed-form reference model.
module tb_seg_text_scroller;

    localparam int ND    = 6;
    localparam int DEPTH = 32;
    localparam int TICK  = 4;
    localparam int BLK   = 3;
    localparam logic [7*ND-1:0] ALL_ONES = {(7*ND){1'b1}};
    localparam logic [6:0] LETTERS [26] = '{
        7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h74, 7'h30, 7'h1E, 7'h75, 7'h38, 7'h37,
        7'h54, 7'h3F, 7'h73, 7'h67, 7'h50, 7'h6D, 7'h78, 7'h3E, 7'h1C, 7'h00, 7'h76, 7'h6E, 7'h5B};
    localparam logic [6:0] DIGITS [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic            clk;
    logic            i_reset, i_wr_en, i_commit;
    logic [4:0]      i_wr_addr;
    logic [7:0]      i_wr_char;
    logic [5:0]      i_msg_len;
    logic [1:0]      i_mode;
    logic [7*ND-1:0] o_hex_out;
    logic [4:0]      o_scroll_pos;
    logic            o_wrap_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: both banks, active selection and cycles since last commit/reset.
    logic [7:0] m_bank [2][DEPTH];
    int         m_act  = 0;
    int         m_len  = 0;
    int         m_mode = 0;
    int         m_n    = 0;
    bit         m_rst  = 1'b1;

    seg_text_scroller #(
        .NUM_DIGITS (ND),
        .MSG_DEPTH  (DEPTH),
        .TICK_DIV   (TICK),
        .BLINK_DIV  (BLK)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_wr_en      (i_wr_en),
        .i_wr_addr    (i_wr_addr),
        .i_wr_char    (i_wr_char),
        .i_commit     (i_commit),
        .i_msg_len    (i_msg_len),
        .i_mode       (i_mode),
        .o_hex_out    (o_hex_out),
        .o_scroll_pos (o_scroll_pos),
        .o_wrap_pulse (o_wrap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [7:0] c);
        if (c >= "A" && c <= "Z") return ~LETTERS[c - 8'h41];
        if (c >= "0" && c <= "9") return ~DIGITS[c - 8'h30];
        if (c == "-") return ~7'h40;
        return 7'h7F;
    endfunction

    // Window start after n cycles: step count folded by len (wrap) or by a triangle wave (bounce).
    function automatic int pos_at(input int n);
        int s, mx, per, t;
        s = n / TICK;
        if (m_mode == 1) return (m_len <= 1) ? 0 : s % m_len;
        if (m_mode == 2 && m_len > ND) begin
            mx  = m_len - ND;
            per = 2 * (mx + 1);
            t   = s % per;
            return (t <= mx) ? t : per - 1 - t;
        end
        return 0;
    endfunction

    function automatic logic exp_pulse();
        int s;
        s = m_n / TICK;
        if (m_n == 0 || (m_n % TICK) != 0) return 1'b0;
        if (m_mode == 1 && m_len > 1) return (s % m_len) == 0;
        if (m_mode == 2 && m_len > ND) return (s % (2 * (m_len - ND + 1))) == 0;
        return 1'b0;
    endfunction

    function automatic logic [7*ND-1:0] exp_hex();
        logic [7*ND-1:0] h;
        int p, idx;
        h = ALL_ONES;
        if (m_n == 0) return h;
        p = pos_at(m_n - 1);
        if (m_mode == 3 && (((m_n - 1) / BLK) % 2) == 1) return h;
        for (int k = 0; k < ND; k++) begin
            idx = (m_mode == 1 && m_len > 0) ? (p + k) % m_len : p + k;
            if (idx < m_len) h[7*k +: 7] = glyph(m_bank[m_act][idx]);
        end
        return h;
    endfunction

    task automatic drive_cycle(input logic rst, input logic wr, input logic [4:0] addr,
                               input logic [7:0] ch, input logic cm, input logic [5:0] len,
                               input logic [1:0] md);
        i_reset = rst; i_wr_en = wr; i_wr_addr = addr; i_wr_char = ch;
        i_commit = cm; i_msg_len = len; i_mode = md;
        @(posedge clk);
        if (wr) m_bank[1 - m_act][addr] = ch;
        if (rst) begin
            m_act = 0; m_len = 0; m_mode = 0; m_n = 0; m_rst = 1'b1;
        end else if (cm) begin
            m_act = 1 - m_act; m_len = (int'(len) > DEPTH) ? DEPTH : int'(len);
            m_mode = int'(md); m_n = 0; m_rst = 1'b0;
        end else begin
            m_n++;
        end
        #1;
        i_reset = 1'b0; i_wr_en = 1'b0; i_commit = 1'b0;
    endtask

    task automatic idle();
        drive_cycle(1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 6'd0, 2'd0);
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [7:0] ch);
        drive_cycle(1'b0, 1'b1, addr, ch, 1'b0, 6'd0, 2'd0);
    endtask

    task automatic do_commit(input logic [5:0] len, input logic [1:0] md);
        drive_cycle(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, len, md);
    endtask

    task automatic write_str(input string s);
        for (int i = 0; i < s.len(); i++) do_write(5'(i), s[i]);
    endtask

    task automatic init_banks();
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < DEPTH; a++) do_write(5'(a), " ");
            do_commit(6'd0, 2'd0);
        end
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 1'b0, 5'd0, 8'd0, 1'b0, 6'd0, 2'd0);
        n_tests++;
        if (o_hex_out !== ALL_ONES) begin
            n_fail++; $display("FAIL reset_hex got %h want %h", o_hex_out, ALL_ONES);
        end
        for (int c = 0; c < 20; c++) begin
            idle();
            n_tests++;
            if (o_hex_out !== ALL_ONES) begin
                n_fail++; $display("FAIL idle_hex got %h want %h", o_hex_out, ALL_ONES);
            end
            n_tests++;
            if (o_scroll_pos !== 5'd0) begin
                n_fail++; $display("FAIL idle_pos got %0d want 0", o_scroll_pos);
            end
            n_tests++;
            if (o_wrap_pulse !== 1'b0) begin
                n_fail++; $display("FAIL idle_pulse got %b want 0", o_wrap_pulse);
            end
        end
    endtask

    task automatic test_static();
        write_str("HELLO");
        do_commit(6'd5, 2'd0);
        for (int c = 1; c <= 14; c++) begin
            if (c == 6) do_write(5'd0, "X"); else idle();
            n_tests++;
            if (o_hex_out !== exp_hex()) begin
                n_fail++; $display("FAIL static_hex got %h want %h", o_hex_out, exp_hex());
            end
            n_tests++;
            if (o_scroll_pos !== 5'd0) begin
                n_fail++; $display("FAIL static_pos got %0d want 0", o_scroll_pos);
            end
            n_tests++;
            if (o_hex_out[6:0] !== 7'b0001011) begin
                n_fail++; $display("FAIL static_H got %b want 0001011", o_hex_out[6:0]);
            end
            if (c == 1) begin
                n_tests++;
                if (o_hex_out[41:35] !== 7'h7F) begin
                    n_fail++; $display("FAIL static_d5 got %h want 7f", o_hex_out[41:35]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int pulses = 0;
        write_str("ABCDEFGH");
        do_commit(6'd8, 2'd1);
        for (int c = 1; c <= 40; c++) begin
            idle();
            if (o_wrap_pulse === 1'b1) pulses++;
            n_tests++;
            if (o_scroll_pos !== 5'(pos_at(m_n))) begin
                n_fail++; $display("FAIL wrap_pos got %0d want %0d", o_scroll_pos, pos_at(m_n));
            end
            n_tests++;
            if (o_wrap_pulse !== exp_pulse()) begin
                n_fail++; $display("FAIL wrap_pulse n=%0d got %b want %b", m_n, o_wrap_pulse, exp_pulse());
            end
            n_tests++;
            if (o_hex_out !== exp_hex()) begin
                n_fail++; $display("FAIL wrap_hex got %h want %h", o_hex_out, exp_hex());
            end
            if (m_n == 7 * TICK + 1) begin
                n_tests++;
                if (o_hex_out[13:0] !== {glyph("A"), 7'b0001011}) begin
                    n_fail++; $display("FAIL wrap_at7 got %h want %h", o_hex_out[13:0], {glyph("A"), 7'b0001011});
                end
            end
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL wrap_pulse_count got %0d want 1", pulses);
        end
    endtask

    task automatic test_bounce();
        int seq [8] = '{0, 1, 2, 2, 1, 0, 0, 1};
        write_str("ABCDEFGH");
        do_commit(6'd8, 2'd2);
        for (int c = 1; c <= 40; c++) begin
            idle();
            if (m_n % TICK == 0 && m_n / TICK < 8) begin
                n_tests++;
                if (o_scroll_pos !== 5'(seq[m_n / TICK])) begin
                    n_fail++; $display("FAIL bounce_seq got %0d want %0d", o_scroll_pos, seq[m_n / TICK]);
                end
            end
            n_tests++;
            if (o_wrap_pulse !== exp_pulse()) begin
                n_fail++; $display("FAIL bounce_pulse n=%0d got %b want %b", m_n, o_wrap_pulse, exp_pulse());
            end
            n_tests++;
            if (o_hex_out !== exp_hex()) begin
                n_fail++; $display("FAIL bounce_hex got %h want %h", o_hex_out, exp_hex());
            end
        end
        do_commit(6'd4, 2'd2);
        for (int c = 1; c <= 30; c++) begin
            idle();
            n_tests++;
            if (o_scroll_pos !== 5'd0 || o_wrap_pulse !== 1'b0) begin
                n_fail++; $display("FAIL bounce_short got pos %0d pulse %b want 0 0", o_scroll_pos, o_wrap_pulse);
            end
            n_tests++;
            if (o_hex_out !== exp_hex()) begin
                n_fail++; $display("FAIL bounce_short_hex got %h want %h", o_hex_out, exp_hex());
            end
        end
    endtask

    task automatic test_blink();
        write_str("ON");
        do_commit(6'd2, 2'd3);
        for (int c = 1; c <= 4; c++) begin
            if (c <= 2) do_write(5'(c - 1), (c == 1) ? 8'h4F : 8'h4E); else idle();
            n_tests++;
            if (o_hex_out !== exp_hex()) begin
                n_fail++; $display("FAIL blink_hex n=%0d got %h want %h", m_n, o_hex_out, exp_hex());
            end
        end
        n_tests++;
        if (o_hex_out !== ALL_ONES) begin
            n_fail++; $display("FAIL blink_off got %h want %h", o_hex_out, ALL_ONES);
        end
        do_commit(6'd2, 2'd3);
        for (int c = 1; c <= 12; c++) begin
            idle();
            if (c == 1) begin
                n_tests++;
                if (o_hex_out[13:0] !== {glyph("N"), glyph("O")}) begin
                    n_fail++; $display("FAIL blink_restore got %h want %h", o_hex_out[13:0], {glyph("N"), glyph("O")});
                end
            end
            n_tests++;
            if (o_hex_out !== exp_hex()) begin
                n_fail++; $display("FAIL blink_hex2 n=%0d got %h want %h", m_n, o_hex_out, exp_hex());
            end
        end
    endtask

    task automatic test_same_cycle();
        drive_cycle(1'b0, 1'b1, 5'd0, "Z", 1'b1, 6'd1, 2'd0);
        idle();
        n_tests++;
        if (o_hex_out[6:0] !== 7'b0100100) begin
            n_fail++; $display("FAIL wr_commit_Z got %b want 0100100", o_hex_out[6:0]);
        end
        n_tests++;
        if (o_hex_out !== exp_hex()) begin
            n_fail++; $display("FAIL wr_commit_hex got %h want %h", o_hex_out, exp_hex());
        end
        drive_cycle(1'b1, 1'b0, 5'd0, 8'd0, 1'b1, 6'd5, 2'd1);
        for (int c = 0; c < 6; c++) begin
            n_tests++;
            if (o_hex_out !== ALL_ONES || o_scroll_pos !== 5'd0) begin
                n_fail++; $display("FAIL rst_commit got hex %h pos %0d want %h 0", o_hex_out, o_scroll_pos, ALL_ONES);
            end
            idle();
        end
    endtask

    task automatic test_random();
        string cs = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789 -?w";
        int r;
        logic [7:0] ch;
        logic [5:0] len;
        for (int c = 0; c < 4000; c++) begin
            r   = int'($urandom_range(0, 999));
            ch  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : cs[$urandom_range(0, cs.len() - 1)];
            len = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 10)) : 6'($urandom_range(0, 40));
            drive_cycle(r < 3, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), ch,
                        r >= 3 && r < 18, len, 2'($urandom_range(0, 3)));
            n_tests++;
            if (o_scroll_pos !== 5'(pos_at(m_n))) begin
                n_fail++; $display("FAIL rand_pos got %0d want %0d", o_scroll_pos, pos_at(m_n));
            end
            n_tests++;
            if (o_wrap_pulse !== exp_pulse()) begin
                n_fail++; $display("FAIL rand_pulse got %b want %b", o_wrap_pulse, exp_pulse());
            end
            if (m_n > 0 || m_rst) begin
                n_tests++;
                if (o_hex_out !== exp_hex()) begin
                    n_fail++; $display("FAIL rand_hex got %h want %h", o_hex_out, exp_hex());
                end
            end
        end
    endtask

    initial begin
        i_reset = 1'b1; i_wr_en = 1'b0; i_commit = 1'b0;
        i_wr_addr = '0; i_wr_char = '0; i_msg_len = '0; i_mode = '0;
        drive_cycle(1'b1, 1'b0, 5'd0, 8'd0, 1'b0, 6'd0, 2'd0);
        init_banks();
        test_reset();
        test_static();
        test_wrap();
        test_bounce();
        test_blink();
        test_same_cycle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_text_scroller.md
Name: seg_text_scroller

Overview:
- Parametrised scrolling text engine for N active-low 7-segment digits. Successor to the fixed 6-digit, hard-wired-message display.
- Messages are written character-by-character into a shadow buffer by a host controller and atomically committed to an active buffer (double-buffered).
- Supports four display modes, with run-time message length and configurable scroll and blink rates.
- Sits between the status/error logic and the board HEX pins.

Parameters:
- NUM_DIGITS, 6, number of physical digits driven; digit 0 is leftmost.
- MSG_DEPTH, 32, characters per buffer bank.
- TICK_DIV, 25_000_000, clk cycles per scroll step.
- BLINK_DIV, 12_500_000, clk cycles per blink half-period.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; all state sampled on rising clk.
- wr_en  in  1  write wr_char into shadow bank at wr_addr.
- wr_addr  in  $clog2(MSG_DEPTH)  shadow write address.
- wr_char  in  8  ASCII character.
- commit  in  1  single-cycle pulse: swap banks, latch msg_len and mode, restart.
- msg_len  in  $clog2(MSG_DEPTH+1)  message length, sampled on commit.
- mode  in  2  00 static, 01 wrap scroll, 10 bounce, 11 blink-static; sampled on commit.
- hex_out  out  7*NUM_DIGITS  segment codes {g..a}, active low. Digit k occupies bits [7k+6:7k].
- scroll_pos  out  $clog2(MSG_DEPTH)  current window start pointer.
- wrap_pulse  out  1  one-cycle pulse when wrap mode returns to 0, or bounce mode reverses at 0.

Behaviour:
Reset:
- hex_out all ones (blank), scroll_pos 0, wrap_pulse 0.
- Active bank 0, active length 0, mode 00, direction up, blink phase on, both counters 0.
- Buffer contents are not cleared; length 0 makes them invisible.

Writes:
- wr_en writes the bank not currently active.
- wr_addr >= MSG_DEPTH is ignored.
- A write in the same cycle as commit lands in the pre-swap shadow, so it is included in the newly active message.
- The shadow is never cleared on swap and holds the stale previous message.

Commit:
- Toggles the active bank.
- Active length = min(msg_len, MSG_DEPTH).
- Latches mode.
- Zeroes scroll_pos, the tick counter and the blink counter; sets direction up and blink phase on.

Timing:
- Tick counter counts 0..TICK_DIV-1; the step fires in the cycle it equals TICK_DIV-1, and the counter returns to 0.
- Blink counter behaves the same with BLINK_DIV and toggles the phase.

Character lookup:
- Char for digit k = active[(scroll_pos + k)] in static, bounce and blink modes; active[(scroll_pos + k) mod len] in wrap mode.
- Any index >= len renders blank. len = 0 renders all blank.
- Glyphs are A-Z (W blank), 0-9, space and '-'; unknown characters render blank.

Modes:
- Static: scroll_pos held at 0.
- Wrap: on step, scroll_pos = (scroll_pos == len-1) ? 0 : scroll_pos+1. The wrap-to-0 cycle asserts wrap_pulse. len <= 1 holds 0 with no pulse.
- Bounce: max = len - NUM_DIGITS if len > NUM_DIGITS, else 0, in which case it holds at 0 with no pulse.
  - Going up, at max: reverse, no move.
  - Going down, at 0: reverse and pulse.
  - Otherwise move ±1.
- Blink: scroll_pos 0; during the off phase all digits are blank.

Latency and priority:
- hex_out is registered: it reflects scroll_pos, bank, length and phase one cycle later.
- wrap_pulse is registered coincident with the scroll_pos update.
- reset beats commit, and commit beats a step in the same cycle.

Decomposition:
- Package seg_text_pkg: mode enum (MODE_STATIC, MODE_WRAP, MODE_BOUNCE, MODE_BLINK) and SEG_BLANK = 7'h7F.
- Sub-module seg7_glyph_rom: combinational 8-bit ASCII to 7-bit active-low decoder, instantiated NUM_DIGITS times.

Test Plan (bench overrides: TICK_DIV=4, BLINK_DIV=3, NUM_DIGITS=6, MSG_DEPTH=32):
1. Reset, then hold idle -> hex_out = all ones, scroll_pos 0, wrap_pulse never asserts.
2. Write "HELLO" at addr 0-4, commit with len 5 and mode 00 -> next cycle digits 0-4 show H,E,L,L,O (H = 0001011) and digit 5 is blank; a further write of "X" without commit leaves the display unchanged.
3. Commit "ABCDEFGH", len 8, mode 01 -> scroll_pos steps every 4 cycles: 0,1,...,7,0. wrap_pulse asserts exactly at the 7->0 step. At pos 7 the digits show H,A,B,C,D,E.
4. Same message, mode 10 -> scroll_pos sequence 0,1,2,2,1,0,0,1,... with wrap_pulse on the reversal at 0. Repeat with len 4 -> scroll_pos stays 0 and there is no pulse.
5. Mode 11 with "ON" -> display alternates between visible and all-blank every 3 cycles; a commit mid-off-phase restores the visible phase one cycle later.
6. Assert wr_en and commit in the same cycle (addr 0, 'Z') -> 'Z' appears in digit 0. Asserting reset together with commit leaves the display blank.
